// File: rtl/sr_pkg.sv
// Shared types and defaults for the S/R latch driver.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2
  } sr_state_e;

  localparam int SR_DEB_CYC_DEF = 4;
  localparam int SR_PULSE_W_DEF = 2;

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// Request/pulse bundle between button-side requester (master) and sr_drive_ctrl (slave).
interface sr_drive_ctrl_if;

  logic set_in;
  logic reset_in;
  logic S;
  logic R;
  logic q_exp;
  logic busy;
  logic conflict;

  modport master (
    output set_in, reset_in,
    input  S, R, q_exp, busy, conflict
  );

  modport slave (
    input  set_in, reset_in,
    output S, R, q_exp, busy, conflict
  );

endinterface

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge detector for one button line.
module sr_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             vld1_q;
  logic             vld2_q;
  logic             level_q;
  logic             level_prev_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;

  // A level already high when reset releases must not count as a press:
  // edges are only reported once a genuine low sample has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      vld1_q       <= 1'b0;
      vld2_q       <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= async_i;
      sync2_q      <= sync1_q;
      vld1_q       <= 1'b1;
      vld2_q       <= vld1_q;
      level_prev_q <= level_q;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      if (vld2_q && !sync2_q && !level_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise_o = level_q & ~level_prev_q & armed_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Turns debounced set/reset button presses into clean, non-overlapping S/R latch pulses.
// Define SR_PULSE_STRETCH_EN to make each pulse PULSE_W cycles long instead of one.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int DEB_CYC = SR_DEB_CYC_DEF,
  parameter int PULSE_W = SR_PULSE_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  sr_drive_ctrl_if.slave bus
);

  logic      rise_s;
  logic      rise_r;
  logic      pulse_end;
  sr_state_e state_q;
  logic      s_q;
  logic      r_q;
  logic      q_exp_q;
  logic      busy_q;
  logic      conflict_q;
  logic      pend_r_q;
  logic      gap_q;

  sr_debounce #(.DEB_CYC(DEB_CYC)) u_deb_set (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.set_in),
    .rise_o  (rise_s)
  );

  sr_debounce #(.DEB_CYC(DEB_CYC)) u_deb_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.reset_in),
    .rise_o  (rise_r)
  );

`ifdef SR_PULSE_STRETCH_EN
  localparam int PW_W = $clog2(PULSE_W + 1);

  logic [PW_W-1:0] pw_cnt_q;

  // Held at zero outside an active pulse, so every pulse starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_cnt_q <= '0;
    end else if (state_q == IDLE || gap_q) begin
      pw_cnt_q <= '0;
    end else if (pw_cnt_q != PW_W'(PULSE_W - 1)) begin
      pw_cnt_q <= pw_cnt_q + 1'b1;
    end
  end

  assign pulse_end = (pw_cnt_q == PW_W'(PULSE_W - 1));
`else
  assign pulse_end = 1'b1;
`endif

  // A reset served straight after a set pulse spends one gap cycle in PULSE_R
  // with both outputs low, so S and R never abut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      q_exp_q    <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      pend_r_q   <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise_r) begin
            state_q    <= PULSE_R;
            r_q        <= 1'b1;
            busy_q     <= 1'b1;
            conflict_q <= rise_s;
          end else if (rise_s) begin
            state_q <= PULSE_S;
            s_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        PULSE_S: begin
          if (rise_r) begin
            pend_r_q <= 1'b1;
          end
          if (pulse_end) begin
            s_q     <= 1'b0;
            q_exp_q <= 1'b1;
            if (pend_r_q || rise_r) begin
              state_q  <= PULSE_R;
              gap_q    <= 1'b1;
              pend_r_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        PULSE_R: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            r_q   <= 1'b1;
          end else if (pulse_end) begin
            r_q     <= 1'b0;
            q_exp_q <= 1'b0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          s_q      <= 1'b0;
          r_q      <= 1'b0;
          busy_q   <= 1'b0;
          pend_r_q <= 1'b0;
          gap_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.q_exp    = q_exp_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed and random checks of sr_drive_ctrl against a behavioural S/R latch.
module tb_sr_drive_ctrl;
  import sr_pkg::*;

  localparam int DEB    = 4;
  localparam int PW_CFG = 4;
`ifdef SR_PULSE_STRETCH_EN
  localparam int PW = PW_CFG;
`else
  localparam int PW = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic latchQ = 1'b0;
  logic sawPulse;
  logic sawLevel;
  int   numCompared   = 0;
  int   numMismatched = 0;
  int   holdLeft;

  sr_drive_ctrl_if bus ();

  sr_drive_ctrl #(.DEB_CYC(DEB), .PULSE_W(PW_CFG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reset-dominant latch fed by the registered S/R pulses.
  always @(posedge clk) begin
    if (bus.R)
      latchQ <= 1'b0;
    else if (bus.S)
      latchQ <= 1'b1;
  end

  task automatic applyStimulus(input logic setV, input logic resetV);
    bus.set_in   = setV;
    bus.reset_in = resetV;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    assert (observed === expected) else begin
      numMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
    rst_n = 1'b0;
    stepCycles(3);
    checkOutput("reset_S", bus.S, 0);
    checkOutput("reset_R", bus.R, 0);
    checkOutput("reset_q_exp", bus.q_exp, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_conflict", bus.conflict, 0);
    rst_n = 1'b1;
    stepCycles(6);

    // Single set press: S after edge DEB+2 for PW cycles, then q_exp=1.
    applyStimulus(1'b1, 1'b0);
    stepCycles(DEB + 2);
    checkOutput("t1_S_early", bus.S, 0);
    checkOutput("t1_busy_early", bus.busy, 0);
    for (int k = 0; k < PW; k++) begin
      stepCycles(1);
      checkOutput("t1_S_pulse", bus.S, 1);
      checkOutput("t1_R_quiet", bus.R, 0);
      checkOutput("t1_busy_pulse", bus.busy, 1);
    end
    stepCycles(1);
    checkOutput("t1_S_end", bus.S, 0);
    checkOutput("t1_q_exp", bus.q_exp, 1);
    checkOutput("t1_busy_end", bus.busy, 0);
    applyStimulus(1'b0, 1'b0);
    sawPulse = 1'b0;
    for (int k = 0; k < 12; k++) begin
      stepCycles(1);
      sawPulse = sawPulse | bus.S | bus.R;
    end
    checkOutput("t1_fall_ignored", sawPulse, 0);

    // Glitch one cycle shorter than the debounce window is rejected.
    applyStimulus(1'b1, 1'b0);
    stepCycles(DEB - 1);
    applyStimulus(1'b0, 1'b0);
    sawPulse = 1'b0;
    sawLevel = 1'b0;
    for (int k = 0; k < 15; k++) begin
      stepCycles(1);
      sawPulse = sawPulse | bus.S | bus.R | bus.busy;
      sawLevel = sawLevel | dut.u_deb_set.level_q;
    end
    checkOutput("t2_no_pulse", sawPulse, 0);
    checkOutput("t2_level_low", sawLevel, 0);
    checkOutput("t2_q_exp_kept", bus.q_exp, 1);

    // A press exactly DEB cycles long is accepted.
    applyStimulus(1'b1, 1'b0);
    stepCycles(DEB);
    applyStimulus(1'b0, 1'b0);
    stepCycles(3);
    checkOutput("t2b_S_pulse", bus.S, 1);
    stepCycles(PW + 12);
    checkOutput("t2b_busy_end", bus.busy, 0);
    checkOutput("t2b_q_exp", bus.q_exp, 1);

    // Reset asserted during a set pulse clears everything at once.
    applyStimulus(1'b1, 1'b0);
    stepCycles(DEB + 3);
    checkOutput("t5_S_pre", bus.S, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_S_async", bus.S, 0);
    checkOutput("t5_R_async", bus.R, 0);
    checkOutput("t5_q_exp_async", bus.q_exp, 0);
    checkOutput("t5_busy_async", bus.busy, 0);
    checkOutput("t5_state_idle", dut.state_q, IDLE);
    stepCycles(2);
    rst_n = 1'b1;
    sawPulse = 1'b0;
    for (int k = 0; k < 20; k++) begin
      stepCycles(1);
      sawPulse = sawPulse | bus.S | bus.R | bus.busy;
    end
    checkOutput("t5_no_repulse", sawPulse, 0);
    checkOutput("t5_q_exp_after", bus.q_exp, 0);
    applyStimulus(1'b0, 1'b0);
    stepCycles(12);

    // Simultaneous set and reset presses: reset wins, conflict flagged once.
    applyStimulus(1'b1, 1'b1);
    stepCycles(DEB + 2);
    checkOutput("t3_R_early", bus.R, 0);
    stepCycles(1);
    checkOutput("t3_R_pulse", bus.R, 1);
    checkOutput("t3_S_quiet", bus.S, 0);
    checkOutput("t3_conflict", bus.conflict, 1);
    checkOutput("t3_busy", bus.busy, 1);
    for (int k = 1; k < PW; k++) begin
      stepCycles(1);
      checkOutput("t3_R_hold", bus.R, 1);
      checkOutput("t3_conflict_clear", bus.conflict, 0);
    end
    stepCycles(1);
    checkOutput("t3_R_end", bus.R, 0);
    checkOutput("t3_conflict_end", bus.conflict, 0);
    checkOutput("t3_q_exp", bus.q_exp, 0);
    checkOutput("t3_busy_end", bus.busy, 0);
    sawPulse = 1'b0;
    for (int k = 0; k < 10; k++) begin
      stepCycles(1);
      sawPulse = sawPulse | bus.S;
    end
    checkOutput("t3_set_dropped", sawPulse, 0);
    applyStimulus(1'b0, 1'b0);
    stepCycles(12);

    // Reset press one cycle after a set press: S pulse, gap, then R pulse.
    applyStimulus(1'b1, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1);
    for (int e = 1; e <= 7 + 2 * PW; e++) begin
      stepCycles(1);
      checkOutput("t4_S_seq", bus.S, ((e >= 6) && (e <= 5 + PW)) ? 1 : 0);
      checkOutput("t4_R_seq", bus.R, ((e >= 7 + PW) && (e <= 6 + 2 * PW)) ? 1 : 0);
      if (e == 6 + PW) begin
        checkOutput("t4_gap_q_exp", bus.q_exp, 1);
        checkOutput("t4_gap_busy", bus.busy, 1);
      end
    end
    checkOutput("t4_q_exp_final", bus.q_exp, 0);
    checkOutput("t4_busy_final", bus.busy, 0);
    applyStimulus(1'b0, 1'b0);
    stepCycles(12);

    // Random button activity; latch must track q_exp whenever idle.
    holdLeft = 0;
    for (int c = 0; c < 10000; c++) begin
      if (holdLeft == 0) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        holdLeft = $urandom_range(1, 12);
      end
      holdLeft--;
      stepCycles(1);
      checkOutput("t6_no_overlap", bus.S & bus.R, 0);
      if (!bus.busy)
        checkOutput("t6_latch_match", bus.q_exp, latchQ);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
